br_ckpt_stack: RTL and testbench

Multi-entry branch checkpoint stack for the R10K-style out-of-order core. It holds DEPTH checkpoints, each containing a map table copy, free-list head and SQ tail. It allocates a one-hot branch tag at dispatch and tracks each checkpoint's dependency mask on older branches. Correct resolution frees the matching entry; wrong resolution squashes that entry and every younger one and supplies recovery data. Stored ready bits follow CDB broadcasts on CDB_NUM ports.

---
 rtl/br_ckpt_stack.sv | 141 ++++++++++++++
 tb/tb_br_ckpt_stack.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/br_ckpt_stack.sv
// Branch checkpoint stack: DEPTH one-hot tagged snapshots of map table, free-list head
// and SQ tail, with dependency masks for squash and CDB-tracked ready bits.
module br_ckpt_stack #(
    parameter int DEPTH     = 4,
    parameter int MT_NUM    = 32,
    parameter int PRF_IDX_W = 6,
    parameter int FL_PTR_W  = 5,
    parameter int SQ_IDX_W  = 3,
    parameter int CDB_NUM   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              disp_br_vld_i,
    input  logic [MT_NUM*(PRF_IDX_W+1)-1:0]   bak_mt_i,
    input  logic [FL_PTR_W:0]                 bak_fl_head_i,
    input  logic [SQ_IDX_W:0]                 bak_sq_tail_i,
    input  logic                              rslv_vld_i,
    input  logic [DEPTH-1:0]                  rslv_1hot_i,
    input  logic                              rslv_wrong_i,
    input  logic [CDB_NUM-1:0]                cdb_vld_i,
    input  logic [CDB_NUM*PRF_IDX_W-1:0]      cdb_tag_i,
    output logic [DEPTH-1:0]                  alloc_1hot_o,
    output logic [DEPTH-1:0]                  br_mask_o,
    output logic                              full_o,
    output logic                              rc_vld_o,
    output logic [MT_NUM*(PRF_IDX_W+1)-1:0]   rc_mt_o,
    output logic [FL_PTR_W:0]                 rc_fl_head_o,
    output logic [SQ_IDX_W:0]                 rc_sq_tail_o,
    output logic [DEPTH-1:0]                  rc_kill_mask_o
);

    localparam int EW   = PRF_IDX_W + 1;
    localparam int MT_W = MT_NUM * EW;

    logic [DEPTH-1:0]   r_live;
    logic [DEPTH-1:0]   r_dep [DEPTH];
    logic [MT_W-1:0]    r_mt  [DEPTH];
    logic [FL_PTR_W:0]  r_fl  [DEPTH];
    logic [SQ_IDX_W:0]  r_sq  [DEPTH];

    logic               w_wrong;
    logic               w_disp;
    logic [DEPTH-1:0]   w_alloc;
    logic [DEPTH-1:0]   w_free;
    logic [DEPTH-1:0]   w_kill;
    logic [DEPTH-1:0]   w_sel;
    logic [MT_W-1:0]    w_cap_mt;
    logic [MT_W-1:0]    w_upd_mt [DEPTH];
    logic [MT_W-1:0]    w_rc_mt_raw;
    logic [FL_PTR_W:0]  w_rc_fl;
    logic [SQ_IDX_W:0]  w_rc_sq;

    // Set the ready bit of every MT element whose tag matches a valid CDB port.
    function automatic logic [MT_W-1:0] f_cdb(input logic [MT_W-1:0] mt,
                                              input logic [CDB_NUM-1:0] vld,
                                              input logic [CDB_NUM*PRF_IDX_W-1:0] tag);
        logic [MT_W-1:0] res;
        res = mt;
        for (int e = 0; e < MT_NUM; e++)
            for (int p = 0; p < CDB_NUM; p++)
                if (vld[p] && mt[e*EW +: PRF_IDX_W] == tag[p*PRF_IDX_W +: PRF_IDX_W])
                    res[e*EW + PRF_IDX_W] = 1'b1;
        return res;
    endfunction

    assign w_wrong = rslv_vld_i & rslv_wrong_i;
    assign w_free  = (rslv_vld_i & ~rslv_wrong_i) ? rslv_1hot_i : '0;
    assign w_disp  = disp_br_vld_i & ~full_o & ~w_wrong;
    assign w_sel   = w_wrong ? rslv_1hot_i : {{(DEPTH-1){1'b0}}, 1'b1};
    assign w_cap_mt = f_cdb(bak_mt_i, cdb_vld_i, cdb_tag_i);

    // Lowest free index wins: the loop runs downward so the last write is the lowest.
    always_comb begin
        w_alloc = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_live[i]) begin
                w_alloc    = '0;
                w_alloc[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_kill      = '0;
        w_rc_mt_raw = '0;
        w_rc_fl     = '0;
        w_rc_sq     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_upd_mt[i] = f_cdb(r_mt[i], cdb_vld_i, cdb_tag_i);
            w_kill[i]   = w_wrong & (rslv_1hot_i[i] | (r_live[i] & (|(r_dep[i] & rslv_1hot_i))));
            w_rc_mt_raw = w_rc_mt_raw | ({MT_W{w_sel[i]}} & r_mt[i]);
            w_rc_fl     = w_rc_fl | ({(FL_PTR_W+1){w_sel[i]}} & r_fl[i]);
            w_rc_sq     = w_rc_sq | ({(SQ_IDX_W+1){w_sel[i]}} & r_sq[i]);
        end
    end

    assign alloc_1hot_o   = w_alloc;
    assign br_mask_o      = r_live;
    assign full_o         = &r_live;
    assign rc_vld_o       = w_wrong;
    assign rc_kill_mask_o = w_kill;
    assign rc_mt_o        = f_cdb(w_rc_mt_raw, cdb_vld_i, cdb_tag_i);
    assign rc_fl_head_o   = w_rc_fl;
    assign rc_sq_tail_o   = w_rc_sq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_live <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dep[i] <= '0;
                r_mt[i]  <= '0;
                r_fl[i]  <= '0;
                r_sq[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_disp && w_alloc[i]) begin
                    r_live[i] <= 1'b1;
                    r_dep[i]  <= r_live & ~w_free;
                    r_mt[i]   <= w_cap_mt;
                    r_fl[i]   <= bak_fl_head_i;
                    r_sq[i]   <= bak_sq_tail_i;
                end else begin
                    if (w_kill[i] || w_free[i])
                        r_live[i] <= 1'b0;
                    r_dep[i] <= r_dep[i] & ~w_free;
                    if (r_live[i])
                        r_mt[i] <= w_upd_mt[i];
                end
            end
        end
    end

    // Resolving a dead or non-one-hot tag is an upstream protocol error.
    always_ff @(posedge clk) begin
        if (!rst && rslv_vld_i) begin
            assert ($onehot(rslv_1hot_i) && ((rslv_1hot_i & r_live) != '0));
        end
    end

endmodule

// File: tb/tb_br_ckpt_stack.sv
// Directed bench for br_ckpt_stack: vector table for alloc/resolve/squash flow, plus
// hand sequences for CDB ready-bit tracking and mid-operation reset.
module tb_br_ckpt_stack;

    localparam int MT_W = 32 * 7;

    logic             clk;
    logic             rst;
    logic             disp_br_vld_i;
    logic [MT_W-1:0]  bak_mt_i;
    logic [5:0]       bak_fl_head_i;
    logic [3:0]       bak_sq_tail_i;
    logic             rslv_vld_i;
    logic [3:0]       rslv_1hot_i;
    logic             rslv_wrong_i;
    logic [1:0]       cdb_vld_i;
    logic [11:0]      cdb_tag_i;
    logic [3:0]       alloc_1hot_o;
    logic [3:0]       br_mask_o;
    logic             full_o;
    logic             rc_vld_o;
    logic [MT_W-1:0]  rc_mt_o;
    logic [5:0]       rc_fl_head_o;
    logic [3:0]       rc_sq_tail_o;
    logic [3:0]       rc_kill_mask_o;

    int n_chk  = 0;
    int n_fail = 0;

    br_ckpt_stack dut (
        .clk(clk), .rst(rst),
        .disp_br_vld_i(disp_br_vld_i), .bak_mt_i(bak_mt_i),
        .bak_fl_head_i(bak_fl_head_i), .bak_sq_tail_i(bak_sq_tail_i),
        .rslv_vld_i(rslv_vld_i), .rslv_1hot_i(rslv_1hot_i), .rslv_wrong_i(rslv_wrong_i),
        .cdb_vld_i(cdb_vld_i), .cdb_tag_i(cdb_tag_i),
        .alloc_1hot_o(alloc_1hot_o), .br_mask_o(br_mask_o), .full_o(full_o),
        .rc_vld_o(rc_vld_o), .rc_mt_o(rc_mt_o), .rc_fl_head_o(rc_fl_head_o),
        .rc_sq_tail_o(rc_sq_tail_o), .rc_kill_mask_o(rc_kill_mask_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       disp;
        logic       rv;
        logic [3:0] r1h;
        logic       wr;
        logic [5:0] fl;
        logic [3:0] e_alloc;
        logic [3:0] e_mask;
        logic       e_full;
        logic       e_rcv;
        logic [3:0] e_kill;
        logic [5:0] e_rcfl;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        disp_br_vld_i = 1'b0;
        bak_mt_i      = '0;
        bak_fl_head_i = '0;
        bak_sq_tail_i = '0;
        rslv_vld_i    = 1'b0;
        rslv_1hot_i   = '0;
        rslv_wrong_i  = 1'b0;
        cdb_vld_i     = '0;
        cdb_tag_i     = '0;
    endtask

    function automatic logic [6:0] elem(input int e);
        return rc_mt_o[e*7 +: 7];
    endfunction

    initial begin
        logic [MT_W-1:0] mt;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_alloc", 64'(alloc_1hot_o), 64'(4'b0001));
        chk("rst_mask",  64'(br_mask_o),    64'(4'b0000));
        chk("rst_full",  64'(full_o),       64'(1'b0));
        chk("rst_rcv",   64'(rc_vld_o),     64'(1'b0));
        chk("rst_rcfl",  64'(rc_fl_head_o), 64'(6'h00));
        chk("rst_rcsq",  64'(rc_sq_tail_o), 64'(4'h0));
        chk("rst_rcmt",  64'(rc_mt_o != '0), 64'(1'b0));

        //         disp  rv    r1h      wr    fl      alloc    mask     full  rcv   kill     rcfl
        tbl[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 6'h01, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[1]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 6'h02, 4'b0010, 4'b0001, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[2]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 6'h03, 4'b0100, 4'b0011, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[3]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 6'h04, 4'b1000, 4'b0111, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[4]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 6'h3F, 4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000, 6'h00};
        tbl[5]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000, 6'h00};
        tbl[6]  = '{1'b0, 1'b1, 4'b0001, 1'b1, 6'h00, 4'b0000, 4'b1111, 1'b1, 1'b1, 4'b1111, 6'h01};
        tbl[7]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[8]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 6'h23, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[9]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 6'h11, 4'b0010, 4'b0001, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[10] = '{1'b1, 1'b0, 4'b0000, 1'b0, 6'h05, 4'b0100, 4'b0011, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[11] = '{1'b0, 1'b1, 4'b0010, 1'b0, 6'h00, 4'b1000, 4'b0111, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[12] = '{1'b1, 1'b0, 4'b0000, 1'b0, 6'h2A, 4'b0010, 4'b0101, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[13] = '{1'b0, 1'b1, 4'b0100, 1'b1, 6'h00, 4'b1000, 4'b0111, 1'b0, 1'b1, 4'b0110, 6'h05};
        tbl[14] = '{1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 4'b0010, 4'b0001, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[15] = '{1'b1, 1'b1, 4'b0001, 1'b1, 6'h3C, 4'b0010, 4'b0001, 1'b0, 1'b1, 4'b0001, 6'h23};
        tbl[16] = '{1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[17] = '{1'b1, 1'b0, 4'b0000, 1'b0, 6'h30, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[18] = '{1'b1, 1'b1, 4'b0001, 1'b0, 6'h31, 4'b0010, 4'b0001, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[19] = '{1'b1, 1'b0, 4'b0000, 1'b0, 6'h32, 4'b0001, 4'b0010, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[20] = '{1'b0, 1'b1, 4'b0001, 1'b1, 6'h00, 4'b0100, 4'b0011, 1'b0, 1'b1, 4'b0001, 6'h32};
        tbl[21] = '{1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 4'b0001, 4'b0010, 1'b0, 1'b0, 4'b0000, 6'h00};
        tbl[22] = '{1'b0, 1'b1, 4'b0010, 1'b1, 6'h00, 4'b0001, 4'b0010, 1'b0, 1'b1, 4'b0010, 6'h31};
        tbl[23] = '{1'b0, 1'b0, 4'b0000, 1'b0, 6'h00, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 6'h00};

        // SQ tail snapshot is a fixed function of the FL head so both fields are checked.
        for (int v = 0; v < 24; v++) begin
            @(negedge clk);
            idle();
            disp_br_vld_i = tbl[v].disp;
            rslv_vld_i    = tbl[v].rv;
            rslv_1hot_i   = tbl[v].r1h;
            rslv_wrong_i  = tbl[v].wr;
            bak_fl_head_i = tbl[v].fl;
            bak_sq_tail_i = tbl[v].fl[3:0] ^ 4'h5;
            #1;
            chk($sformatf("v%0d_alloc", v), 64'(alloc_1hot_o), 64'(tbl[v].e_alloc));
            chk($sformatf("v%0d_mask", v),  64'(br_mask_o),    64'(tbl[v].e_mask));
            chk($sformatf("v%0d_full", v),  64'(full_o),       64'(tbl[v].e_full));
            chk($sformatf("v%0d_rcv", v),   64'(rc_vld_o),     64'(tbl[v].e_rcv));
            if (tbl[v].e_rcv) begin
                chk($sformatf("v%0d_kill", v), 64'(rc_kill_mask_o), 64'(tbl[v].e_kill));
                chk($sformatf("v%0d_rcfl", v), 64'(rc_fl_head_o),   64'(tbl[v].e_rcfl));
                chk($sformatf("v%0d_rcsq", v), 64'(rc_sq_tail_o),   64'(tbl[v].e_rcfl[3:0] ^ 4'h5));
            end
        end

        // CDB: capture-cycle hit on 0x2A, later hit on 0x15 via port 1.
        @(negedge clk);
        idle();
        mt = '0;
        mt[3*7 +: 7] = {1'b0, 6'h15};
        mt[7*7 +: 7] = {1'b0, 6'h2A};
        disp_br_vld_i = 1'b1;
        bak_mt_i      = mt;
        cdb_vld_i     = 2'b01;
        cdb_tag_i     = {6'h00, 6'h2A};
        #1;
        chk("cdb_alloc", 64'(alloc_1hot_o), 64'(4'b0001));
        @(negedge clk);
        idle();
        cdb_vld_i = 2'b10;
        cdb_tag_i = {6'h15, 6'h33};
        @(negedge clk);
        idle();
        rslv_vld_i = 1'b1; rslv_1hot_i = 4'b0001; rslv_wrong_i = 1'b1;
        #1;
        chk("cdb_rcv",   64'(rc_vld_o),       64'(1'b1));
        chk("cdb_kill",  64'(rc_kill_mask_o), 64'(4'b0001));
        chk("cdb_e3",    64'(elem(3)),        64'({1'b1, 6'h15}));
        chk("cdb_e7",    64'(elem(7)),        64'({1'b1, 6'h2A}));
        chk("cdb_e0",    64'(elem(0)),        64'(7'h00));

        // Same-cycle CDB bypass onto the recovery map table.
        @(negedge clk);
        idle();
        mt = '0;
        mt[5*7 +: 7] = {1'b0, 6'h09};
        mt[3*7 +: 7] = {1'b0, 6'h15};
        disp_br_vld_i = 1'b1;
        bak_mt_i      = mt;
        #1;
        chk("byp_alloc", 64'(alloc_1hot_o), 64'(4'b0001));
        @(negedge clk);
        idle();
        rslv_vld_i = 1'b1; rslv_1hot_i = 4'b0001; rslv_wrong_i = 1'b1;
        cdb_vld_i  = 2'b11;
        cdb_tag_i  = {6'h3F, 6'h09};
        #1;
        chk("byp_e5", 64'(elem(5)), 64'({1'b1, 6'h09}));
        chk("byp_e3", 64'(elem(3)), 64'({1'b0, 6'h15}));
        @(negedge clk);
        idle();
        #1;
        chk("byp_mask", 64'(br_mask_o), 64'(4'b0000));

        // Reset with three live entries and a dispatch pending.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle();
            disp_br_vld_i = 1'b1;
            bak_fl_head_i = 6'h2B;
        end
        @(negedge clk);
        idle();
        #1;
        chk("pre_rst_mask", 64'(br_mask_o), 64'(4'b0111));
        @(negedge clk);
        idle();
        rst = 1'b1;
        disp_br_vld_i = 1'b1;
        bak_fl_head_i = 6'h1E;
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        chk("mrst_mask",  64'(br_mask_o),    64'(4'b0000));
        chk("mrst_alloc", 64'(alloc_1hot_o), 64'(4'b0001));
        chk("mrst_full",  64'(full_o),       64'(1'b0));
        chk("mrst_rcv",   64'(rc_vld_o),     64'(1'b0));
        chk("mrst_rcfl",  64'(rc_fl_head_o), 64'(6'h00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
